// File: rtl/demux4_framer_pkg.sv
// Shared constants and state encoding for the 4-lane receive framer.
package demux4_framer_pkg;

  localparam int unsigned NLANES = 4;
  localparam int unsigned SLOT_W = 2;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/demux4_framer_if.sv
// Serial-in / parallel-out bus between the link receiver and the framer.
interface demux4_framer_if
  import demux4_framer_pkg::*;
#(
  parameter int unsigned WIDTH = 1
);
  logic                     en;
  logic                     sync;
  logic [WIDTH-1:0]         din;
  logic [SLOT_W-1:0]        sel_out;
  logic [NLANES*WIDTH-1:0]  lane;
  logic                     frame_valid;
  logic                     sync_err;

  modport master (
    output en, sync, din,
    input  sel_out, lane, frame_valid, sync_err
  );

  modport slave (
    input  en, sync, din,
    output sel_out, lane, frame_valid, sync_err
  );
endinterface

// File: rtl/demux4_framer_slot_timer.sv
// Slot sequencer: divides the clock into DIV-cycle slots and counts slots 0..3.
module demux4_framer_slot_timer
  import demux4_framer_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              run_i,
  input  logic              clear_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic              tick_o,
  output logic              slot_last_o,
  output logic              boundary_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0]   div_cnt_q, div_cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  // Sample point is the last cycle of each slot.
  assign tick_o      = en_i & run_i & (div_cnt_q == CntLast);
  assign slot_last_o = (slot_q == SLOT_W'(NLANES - 1));
  assign boundary_o  = (slot_q == '0) && (div_cnt_q == '0);
  assign slot_o      = slot_q;

  // Next-state: clear wins, otherwise advance only while running and enabled.
  always_comb begin
    div_cnt_d = div_cnt_q;
    slot_d    = slot_q;
    if (clear_i) begin
      div_cnt_d = '0;
      slot_d    = '0;
    end else if (en_i && run_i) begin
      if (tick_o) begin
        div_cnt_d = '0;
        slot_d    = slot_q + SLOT_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + CntW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      slot_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      slot_q    <= slot_d;
    end
  end

endmodule

// File: rtl/demux4_framer.sv
// Receive-side 1:4 demultiplexer: routes serial slots back to lanes and
// publishes each complete frame as one atomically updated parallel word.
module demux4_framer
  import demux4_framer_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DIV   = 1
) (
  input logic           clk,
  input logic           rst,
  demux4_framer_if.slave bus
);

  state_e state_q, state_d;

  // Slots 0..2 only; slot 3 goes straight from din into lane.
  logic [NLANES-2:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [NLANES*WIDTH-1:0]      lane_q, lane_d;
  logic                         frame_valid_q, frame_valid_d;
  logic                         sync_err_q, sync_err_d;

  logic              clear;
  logic              tick;
  logic              slot_last;
  logic              boundary;
  logic [SLOT_W-1:0] slot;

  demux4_framer_slot_timer #(
    .DIV (DIV)
  ) u_slot_timer (
    .clk         (clk),
    .rst         (rst),
    .en_i        (bus.en),
    .run_i       (state_q == StRun),
    .clear_i     (clear),
    .slot_o      (slot),
    .tick_o      (tick),
    .slot_last_o (slot_last),
    .boundary_o  (boundary)
  );

  // FSM next-state, slot capture and frame publication.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    lane_d        = lane_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    clear         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en && bus.sync) begin
          state_d = StRun;
          clear   = 1'b1;
        end
      end
      StRun: begin
        if (bus.en) begin
          // Sync on a frame boundary or on the completing tick is benign.
          if (bus.sync && !boundary && !(tick && slot_last)) begin
            sync_err_d = 1'b1;
            clear      = 1'b1;
            shadow_d   = '0;
          end else if (tick) begin
            if (slot_last) begin
              lane_d        = {bus.din, shadow_q[2], shadow_q[1], shadow_q[0]};
              frame_valid_d = 1'b1;
            end else begin
              shadow_d[slot] = bus.din;
            end
          end
        end
      end
    endcase
  end

  // State, data and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      shadow_q      <= '0;
      lane_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      lane_q        <= lane_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign bus.sel_out     = (state_q == StRun) ? slot : '0;
  assign bus.lane        = lane_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_demux4_framer.sv
// Directed bench for demux4_framer with a lane scoreboard per instance.
module tb_demux4_framer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  demux4_framer_if #(.WIDTH(1)) ia ();
  demux4_framer_if #(.WIDTH(4)) ib ();

  demux4_framer #(.WIDTH(1), .DIV(1)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  demux4_framer #(.WIDTH(4), .DIV(3)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Any frame_valid pulse must match the oldest expected lane word.
  task automatic mon();
    logic [15:0] e;
    if (ia.frame_valid === 1'b1) begin
      if (exp_a.size() == 0) chk("a_unexpected_frame_valid", 32'd1, 32'd0);
      else begin
        e = exp_a.pop_front();
        chk("a_lane", 32'(ia.lane), 32'(e));
      end
    end
    if (ib.frame_valid === 1'b1) begin
      if (exp_b.size() == 0) chk("b_unexpected_frame_valid", 32'd1, 32'd0);
      else begin
        e = exp_b.pop_front();
        chk("b_lane", 32'(ib.lane), 32'(e));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    mon();
  endtask

  // One DIV=1 frame on instance A starting at a frame boundary; slot k gets pat[k].
  task automatic frame_a(input logic [3:0] pat, input logic [3:0] sync_mask);
    for (int k = 0; k < 4; k++) begin
      ia.din  = pat[k];
      ia.sync = sync_mask[k];
      if (k == 3) exp_a.push_back(16'(pat));
      cyc();
      chk("a_sel", 32'(ia.sel_out), 32'((k + 1) % 4));
      chk("a_fv", 32'(ia.frame_valid), 32'(k == 3));
      chk("a_err", 32'(ia.sync_err), 32'd0);
    end
    ia.sync = 1'b0;
  endtask

  initial begin
    logic [3:0] pat;
    rst = 1'b1;
    ia.en = 1'b0; ia.sync = 1'b0; ia.din = '0;
    ib.en = 1'b0; ib.sync = 1'b0; ib.din = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    cyc();
    chk("rst_a_lane", 32'(ia.lane), 32'd0);
    chk("rst_a_sel", 32'(ia.sel_out), 32'd0);
    chk("rst_a_fv", 32'(ia.frame_valid), 32'd0);
    chk("rst_a_err", 32'(ia.sync_err), 32'd0);
    chk("rst_b_lane", 32'(ib.lane), 32'd0);

    // Slow slots on B: DIV=3, WIDTH=4.
    ib.en = 1'b1; ib.sync = 1'b1;
    cyc();
    chk("b_sel_start", 32'(ib.sel_out), 32'd0);
    ib.sync = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      ib.din = 4'(10 + (j - 1) / 3);
      if (j == 12) exp_b.push_back(16'hDCBA);
      cyc();
      chk("b_sel", 32'(ib.sel_out), 32'((j / 3) % 4));
      chk("b_fv", 32'(ib.frame_valid), 32'(j == 12));
    end
    ib.en = 1'b0;
    cyc();
    chk("b_fv_drop", 32'(ib.frame_valid), 32'd0);
    chk("b_lane_hold", 32'(ib.lane), 32'hDCBA);

    // Basic frame on A: sync then 1,0,1,1.
    ia.en = 1'b1; ia.sync = 1'b1; ia.din = 1'b1;
    cyc();
    chk("a_sel_e0", 32'(ia.sel_out), 32'd0);
    frame_a(4'b1101, 4'b0000);

    // Mid-frame sync at slot 1 resynchronises and discards the partial frame.
    ia.din = 1'b0;
    cyc();
    chk("a_sel_pre_resync", 32'(ia.sel_out), 32'd1);
    ia.sync = 1'b1; ia.din = 1'b1;
    cyc();
    chk("a_resync_err", 32'(ia.sync_err), 32'd1);
    chk("a_resync_sel", 32'(ia.sel_out), 32'd0);
    chk("a_resync_fv", 32'(ia.frame_valid), 32'd0);
    chk("a_resync_lane_hold", 32'(ia.lane), 32'hD);
    frame_a(4'b0110, 4'b0000);

    // Enable gap of 5 cycles after slot 1; sync during the gap is ignored.
    ia.din = 1'b1; cyc();
    ia.din = 1'b1; cyc();
    chk("a_sel_gap_start", 32'(ia.sel_out), 32'd2);
    ia.en = 1'b0; ia.sync = 1'b1;
    for (int g = 0; g < 5; g++) begin
      ia.din = 1'b0;
      cyc();
      chk("a_gap_sel", 32'(ia.sel_out), 32'd2);
      chk("a_gap_fv", 32'(ia.frame_valid), 32'd0);
      chk("a_gap_err", 32'(ia.sync_err), 32'd0);
    end
    ia.en = 1'b1; ia.sync = 1'b0;
    ia.din = 1'b0; cyc();
    chk("a_sel_after_gap", 32'(ia.sel_out), 32'd3);
    ia.din = 1'b1; exp_a.push_back(16'hB);
    cyc();
    chk("a_gap_frame_fv", 32'(ia.frame_valid), 32'd1);
    ia.en = 1'b0;
    cyc();
    chk("a_fv_drop_en_low", 32'(ia.frame_valid), 32'd0);
    chk("a_lane_hold_en_low", 32'(ia.lane), 32'hB);
    ia.en = 1'b1;

    // Back-to-back frames with sync on each boundary.
    for (int f = 0; f < 3; f++) begin
      pat = 4'($urandom_range(0, 15));
      frame_a(pat, 4'b0001);
    end

    // Sync on the slot-3 tick completes the frame without an error.
    frame_a(4'b0101, 4'b1000);
    frame_a(4'b1001, 4'b0000);

    // Asynchronous reset mid-frame.
    ia.din = 1'b1; cyc(); cyc();
    chk("a_sel_pre_rst", 32'(ia.sel_out), 32'd2);
    rst = 1'b1;
    #1;
    chk("a_rst_async_lane", 32'(ia.lane), 32'd0);
    chk("a_rst_async_sel", 32'(ia.sel_out), 32'd0);
    chk("a_rst_async_fv", 32'(ia.frame_valid), 32'd0);
    chk("b_rst_async_lane", 32'(ib.lane), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("a_idle_sel", 32'(ia.sel_out), 32'd0);
      chk("a_idle_lane", 32'(ia.lane), 32'd0);
    end
    ia.sync = 1'b1;
    cyc();
    ia.sync = 1'b0;
    frame_a(4'b0011, 4'b0000);

    cyc();
    chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
